// File: rtl/gram_pkg.sv
// Shared definitions for the Gram-matrix accumulator: FSM encoding, the
// upper-triangle entry count and the signed saturation helper.
package gram_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    function automatic int tri_count(input int n);
        return n * (n + 1) / 2;
    endfunction

    // Clamp v to the signed range of a w-bit two's complement number.
    function automatic longint saturate(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/gram_accum_mac.sv
// gram_mac: signed WIDTH x WIDTH multiply, arithmetic shift by FRAC, and a
// wrapping add into a WIDTH+GUARD accumulator.
module gram_mac #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int GUARD = 8
) (
    input  logic signed [WIDTH-1:0]       a,
    input  logic signed [WIDTH-1:0]       b,
    input  logic signed [WIDTH+GUARD-1:0] acc_in,
    output logic signed [WIDTH+GUARD-1:0] acc_out
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = WIDTH + GUARD;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;

    assign prod    = PW'(a) * PW'(b);
    assign prod_sh = prod >>> FRAC;
    // The size cast truncates or sign-extends; the add wraps at AW bits.
    assign acc_out = AW'(prod_sh) + acc_in;

endmodule

// File: rtl/gram_accum.sv
// Gram-matrix accumulator: A = sum of x*x^T over NSAMP sample vectors, one
// upper-triangle entry per cycle. Optional macro GRAM_ACCUM_RIDGE_EN adds RIDGE on the diagonal.
module gram_accum
    import gram_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SIZE  = 3,
    parameter int FRAC  = 8,
    parameter int NSAMP = 8,
    parameter int GUARD = 8
`ifdef GRAM_ACCUM_RIDGE_EN
    , parameter int RIDGE = 1 << FRAC
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x_valid,
    input  logic [WIDTH*SIZE-1:0]         x,
    output logic                          x_ready,
    output logic [WIDTH*SIZE*SIZE-1:0]    a,
    output logic                          a_valid,
    input  logic                          ack,
    output logic [1:0]                    state_dbg
);

    // Handshakes: x is taken on a rising edge where x_valid && x_ready; a is
    // held while a_valid=1 and released on the edge that samples ack=1.

    localparam int TRI = tri_count(SIZE);
    localparam int AW  = WIDTH + GUARD;
    localparam int EW  = (TRI > 1) ? $clog2(TRI) : 1;
    localparam int RW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int NW  = $clog2(NSAMP + 1);

    logic [1:0]              state;
    logic signed [WIDTH-1:0] x_lat [SIZE];
    logic signed [AW-1:0]    acc   [TRI];
    logic [EW-1:0]           e_idx;
    logic [RW-1:0]           r_idx;
    logic [RW-1:0]           c_idx;
    logic [NW-1:0]           samp_cnt;
    logic signed [AW-1:0]    mac_out;

    gram_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_mac (
        .a       (x_lat[r_idx]),
        .b       (x_lat[c_idx]),
        .acc_in  (acc[e_idx]),
        .acc_out (mac_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            e_idx    <= '0;
            r_idx    <= '0;
            c_idx    <= '0;
            samp_cnt <= '0;
            for (int i = 0; i < SIZE; i++) x_lat[i] <= '0;
            for (int i = 0; i < TRI; i++)  acc[i]   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (x_valid) begin
                        for (int i = 0; i < SIZE; i++) x_lat[i] <= x[WIDTH*i +: WIDTH];
                        e_idx <= '0;
                        r_idx <= '0;
                        c_idx <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc[e_idx] <= mac_out;
                    e_idx      <= e_idx + EW'(1);
                    // Walk (r,c) row-major over r <= c; the next row starts on the diagonal.
                    if (c_idx == RW'(SIZE - 1)) begin
                        if (r_idx == RW'(SIZE - 1)) begin
                            samp_cnt <= samp_cnt + NW'(1);
                            state    <= (samp_cnt == NW'(NSAMP - 1)) ? ST_OUT : ST_LOAD;
                        end else begin
                            r_idx <= r_idx + RW'(1);
                            c_idx <= r_idx + RW'(1);
                        end
                    end else begin
                        c_idx <= c_idx + RW'(1);
                    end
                end
                ST_OUT: begin
                    if (ack) begin
                        for (int i = 0; i < TRI; i++) acc[i] <= '0;
                        samp_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign x_ready   = rst && (state == ST_IDLE || state == ST_LOAD);
    assign a_valid   = (state == ST_OUT);
    assign state_dbg = state;

    // Both (r,c) and (c,r) read the same upper-triangle accumulator.
    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            localparam int LO = (r < c) ? r : c;
            localparam int HI = (r < c) ? c : r;
            localparam int TI = LO * SIZE - LO * (LO - 1) / 2 + (HI - LO);
`ifdef GRAM_ACCUM_RIDGE_EN
            localparam longint RADD = (r == c) ? longint'(RIDGE) : longint'(0);
`else
            localparam longint RADD = 0;
`endif
            assign a[WIDTH*(r*SIZE+c) +: WIDTH] = (state == ST_OUT)
                ? WIDTH'(saturate(longint'(acc[TI]) + RADD, WIDTH)) : '0;
        end
    end

endmodule

// File: tb/tb_gram_accum.sv
// Directed bench for gram_accum (NSAMP=2): a sample-level model predicts
// readiness, validity and the saturated Gram matrix every cycle.
module tb_gram_accum;

    localparam int W   = 16;
    localparam int S   = 3;
    localparam int F   = 8;
    localparam int N   = 2;
    localparam int G   = 8;
    localparam int TRI = 6;
    localparam int AW  = W + G;
    localparam int MW  = W * S * S;
`ifdef GRAM_ACCUM_RIDGE_EN
    localparam longint RADD = longint'(1) << F;
`else
    localparam longint RADD = 0;
`endif

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          x_valid = 1'b0;
    logic          ack = 1'b0;
    logic [W*S-1:0] x = '0;
    logic          x_ready;
    logic          a_valid;
    logic [MW-1:0] a;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gram_accum #(
        .WIDTH (W),
        .SIZE  (S),
        .FRAC  (F),
        .NSAMP (N),
        .GUARD (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_valid   (x_valid),
        .x         (x),
        .x_ready   (x_ready),
        .a         (a),
        .a_valid   (a_valid),
        .ack       (ack),
        .state_dbg (state_dbg)
    );

    // model / scoreboard
    longint        m_acc [S][S];
    int            m_n = 0;
    longint        cyc = 0;
    longint        last_acc = -1000;
    logic [MW-1:0] exp_q[$];

    function automatic longint wrap_aw(input longint v);
        longint t;
        t = v & ((longint'(1) << AW) - 1);
        if (t >= (longint'(1) << (AW - 1))) t = t - (longint'(1) << AW);
        return t;
    endfunction

    function automatic longint sat_w(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic bit exp_ready();
        return rst && (cyc - last_acc >= TRI) && (m_n < N);
    endfunction

    function automatic bit exp_valid();
        return rst && (m_n == N) && (cyc - last_acc >= TRI);
    endfunction

    function automatic logic [W*S-1:0] vec(input int e0, input int e1, input int e2);
        logic [W*S-1:0] v;
        v[0 +: W]   = W'(e0);
        v[W +: W]   = W'(e1);
        v[2*W +: W] = W'(e2);
        return v;
    endfunction

    function automatic longint elem(input int r, input int c);
        logic signed [W-1:0] e;
        e = a[W*(r*S+c) +: W];
        return longint'(e);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) m_acc[r][c] = 0;
        m_n = 0;
    endtask

    task automatic model_accept(input logic [W*S-1:0] v);
        logic signed [W-1:0] xr;
        logic signed [W-1:0] xc;
        logic [MW-1:0]       flat;
        longint              e;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                xr = v[W*r +: W];
                xc = v[W*c +: W];
                m_acc[r][c] = wrap_aw(m_acc[r][c] + ((longint'(xr) * longint'(xc)) >>> F));
            end
        m_n++;
        last_acc = cyc;
        if (m_n == N) begin
            flat = '0;
            for (int r = 0; r < S; r++)
                for (int c = 0; c < S; c++) begin
                    e = sat_w(m_acc[r][c] + ((r == c) ? RADD : 0));
                    flat[W*(r*S+c) +: W] = e[W-1:0];
                end
            exp_q.push_back(flat);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_clear();
            last_acc = -1000;
            exp_q.delete();
        end else begin
            bit rdy;
            bit vld;
            rdy = exp_ready();
            vld = exp_valid();
            cyc++;
            if (x_valid && rdy) model_accept(x);
            if (ack && vld) begin
                model_clear();
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("x_ready", longint'(x_ready), longint'(exp_ready()));
            chk("a_valid", longint'(a_valid), longint'(exp_valid()));
            if (exp_valid()) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL matrix: got %h, expected none pending", a);
                end else if (a !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL matrix: got %h, expected %h", a, exp_q[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic send(input logic [W*S-1:0] v);
        int k;
        @(negedge clk);
        x       = v;
        x_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            if (x_ready) break;
            @(negedge clk);
        end
        if (k == 100) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wait_valid(output longint at_cyc);
        int k;
        for (k = 0; k < 200; k++) begin
            if (a_valid) break;
            @(negedge clk);
        end
        if (k == 200) chk("a_valid_timeout", 0, 1);
        at_cyc = cyc;
    endtask

    task automatic do_ack(input int delay);
        logic [MW-1:0] snap;
        snap = a;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            n_tests++;
            if (a !== snap || a_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold: got %h v=%0b, expected %h v=1", a, a_valid, snap);
            end
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_drop", longint'(a_valid), 0);
    endtask

    initial begin
        longint t0;
        longint t1;
        longint tv;

        // reset state
        #2;
        chk("rst_x_ready", longint'(x_ready), 0);
        chk("rst_a_valid", longint'(a_valid), 0);
        chk("rst_a", (a == '0) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", longint'(x_ready), 1);

        // (256,0,0) twice, x_valid held high: spacing and latency
        send(vec(256, 0, 0));
        t0 = cyc;
        send(vec(256, 0, 0));
        t1 = cyc;
        drop_valid();
        chk("accept_spacing", t1 - t0, TRI + 1);
        wait_valid(tv);
        chk("latency", tv - t0, 13);
        chk("a00_unit", elem(0, 0), 512 + RADD);
        chk("a01_unit", elem(0, 1), 0);
        chk("a10_unit", elem(1, 0), 0);
        do_ack(5);

        // ack pulse in IDLE
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_valid", longint'(a_valid), 0);
        chk("idle_ack_ready", longint'(x_ready), 1);

        // (256,512,768) then a zero vector, with an idle gap
        send(vec(256, 512, 768));
        drop_valid();
        repeat (8) @(negedge clk);
        send(vec(0, 0, 0));
        drop_valid();
        wait_valid(tv);
        chk("a00_ramp", elem(0, 0), 256 + RADD);
        chk("a01_ramp", elem(0, 1), 512);
        chk("a12_ramp", elem(1, 2), 1536);
        chk("a21_ramp", elem(2, 1), 1536);
        chk("a22_ramp", elem(2, 2), 2304 + RADD);
        do_ack(0);

        // positive saturation
        send(vec(32767, 0, 0));
        send(vec(32767, 0, 0));
        drop_valid();
        wait_valid(tv);
        chk("a00_sat", elem(0, 0), 32767);
        do_ack(1);

        // negative saturation and accumulator wrap on (1,1)
        send(vec(32767, -32768, 0));
        send(vec(32767, -32768, 0));
        drop_valid();
        wait_valid(tv);
        chk("a01_negsat", elem(0, 1), -32768);
        chk("a10_negsat", elem(1, 0), -32768);
        chk("a11_wrap", elem(1, 1), -32768);
        do_ack(2);

        // arithmetic shift floors negative products
        send(vec(-1, 3, 0));
        send(vec(0, 0, 0));
        drop_valid();
        wait_valid(tv);
        chk("a01_floor", elem(0, 1), -1);
        chk("a11_small", elem(1, 1), RADD);
        do_ack(0);

        // reset in the middle of the second sample, then a fresh run
        send(vec(100, 200, 300));
        send(vec(5, 6, 7));
        drop_valid();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ready", longint'(x_ready), 0);
        chk("midrst_valid", longint'(a_valid), 0);
        chk("midrst_a", (a == '0) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        send(vec(512, -256, 128));
        send(vec(256, 256, 256));
        drop_valid();
        wait_valid(tv);
        chk("a00_fresh", elem(0, 0), 1280 + RADD);
        chk("a01_fresh", elem(0, 1), -256);
        chk("a12_fresh", elem(1, 2), 128);
        chk("a22_fresh", elem(2, 2), 320 + RADD);
        do_ack(3);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
